capture_buffer: RTL and testbench

Single-shot sample buffer sitting directly downstream of the octal LVDS capture stage, in the frame-clock (`clkout`) domain. When armed, it stores the two selected 14-bit channel words presented on every `load` strobe into an on-chip RAM until the RAM is full. It then holds the record for word-by-word readout by the host interface logic.

---
 rtl/capture_pkg.sv | 30 +++
 rtl/sample_ram.sv | 46 ++++
 rtl/capture_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_capture_buffer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
// Shared definitions for the capture buffer slice:
//   - state_t       : FSM state encoding (ST_IDLE, ST_FILL, ST_DONE)
//   - DATA_W_DEF    : default sample width per channel (<= 16)
//   - ADDR_W_DEF    : default RAM address width (depth = 2^ADDR_W pairs)
//   - RD_W          : width of the host read word
//   - pack_pair()   : builds the host word {pad, b, pad, a} from 16-bit halves
// Optional build macro used by capture_buffer: CAPTURE_RAMP_EN.
// -----------------------------------------------------------------------------
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 14;
    localparam int ADDR_W_DEF = 14;
    localparam int RD_W       = 32;

    // Callers zero-extend each channel to 16 bits, so the pad falls out of the
    // concatenation.
    function automatic logic [RD_W-1:0] pack_pair(input logic [15:0] a,
                                                   input logic [15:0] b);
        return {b, a};
    endfunction

endpackage

// File: rtl/sample_ram.sv
// -----------------------------------------------------------------------------
// sample_ram
// Simple dual-port RAM: one write port, one read port with a registered
// output (one cycle latency). Written so synthesis maps it to block RAM;
// contents have no reset.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable;  waddr/wdata : write address/data
//   re    : read enable;   raddr       : read address
//   rdata : registered read data, updated only on a cycle with re=1
// -----------------------------------------------------------------------------
module sample_ram #(
    parameter int WIDTH  = 28,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/capture_buffer.sv
// -----------------------------------------------------------------------------
// capture_buffer
// Single-shot sample buffer in the frame-clock domain. When armed it stores
// {din_b, din_a} on every load strobe until the RAM is full, then holds the
// record for word-by-word host readout.
// Ports:
//   clk, rst         : clock (rising edge), synchronous active-high reset
//   arm              : start/restart capture (level-sampled)
//   load, din_a/b    : sample strobe and the two channel words
//   rd_en            : host read request, one word per cycle
//   rd_data/rd_valid : {pad, b, pad, a} one cycle after the accepted read edge
//   busy / done      : state is FILL / DONE
//   wr_count         : pairs written in the current record (0 .. 2^ADDR_W)
//   ramp_sel         : only when CAPTURE_RAMP_EN is defined; stores a
//                      pointer ramp (A = wr_ptr, B = ~A) instead of live data
// -----------------------------------------------------------------------------
module capture_buffer
    import capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              load,
    input  logic [DATA_W-1:0] din_a,
    input  logic [DATA_W-1:0] din_b,
    input  logic              rd_en,
`ifdef CAPTURE_RAMP_EN
    input  logic              ramp_sel,
`endif
    output logic [RD_W-1:0]   rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
);

    // Count value just before the final write, and the last read address.
    localparam logic [ADDR_W:0]   LAST_WR_CNT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR   = {ADDR_W{1'b1}};

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic [ADDR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic                rd_pend_q,  rd_pend_d;
    logic                rd_valid_q, rd_valid_d;
    logic [RD_W-1:0]     rd_data_q,  rd_data_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;

    logic                ram_we;
    logic                ram_re;
    logic [DATA_W-1:0]   wr_a;
    logic [DATA_W-1:0]   wr_b;
    logic [2*DATA_W-1:0] ram_rdata;

`ifdef CAPTURE_RAMP_EN
    // Zero-extend (or truncate) the write pointer to one sample word.
    logic [DATA_W+ADDR_W-1:0] ptr_ext;
    logic [DATA_W-1:0]        ramp_a;
    assign ptr_ext = {{DATA_W{1'b0}}, wr_ptr_q};
    assign ramp_a  = ptr_ext[DATA_W-1:0];

    // Select the ramp pattern or live samples as write data.
    always_comb begin
        wr_a = din_a;
        wr_b = din_b;
        if (ramp_sel) begin
            wr_a = ramp_a;
            wr_b = ~ramp_a;
        end else begin
            wr_a = din_a;
            wr_b = din_b;
        end
    end
`else
    // Live samples are always the write data.
    always_comb begin
        wr_a = din_a;
        wr_b = din_b;
    end
`endif

    // Next-state, pointer and RAM-port control for the capture FSM.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        rd_ptr_d   = rd_ptr_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d    = ST_FILL;
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                    rd_ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (load) begin
                    ram_we     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                    wr_count_d = wr_count_q + (ADDR_W+1)'(1);
                    if (wr_count_q == LAST_WR_CNT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DONE: begin
                // A re-arm takes priority and suppresses any same-cycle read.
                if (arm) begin
                    state_d    = ST_FILL;
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                    rd_ptr_d   = '0;
                end else if (rd_en) begin
                    ram_re   = 1'b1;
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    if (rd_ptr_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register values: status follows the next state, read data is
    // captured one cycle after the RAM read was issued.
    always_comb begin
        busy_d     = (state_d == ST_FILL);
        done_d     = (state_d == ST_DONE);
        rd_pend_d  = ram_re;
        rd_valid_d = rd_pend_q;
        if (rd_pend_q) begin
            rd_data_d = pack_pair(16'(ram_rdata[DATA_W-1:0]),
                                  16'(ram_rdata[2*DATA_W-1:DATA_W]));
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            rd_ptr_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    sample_ram #(
        .WIDTH  (2*DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata ({wr_b, wr_a}),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_capture_buffer
// Directed self-checking bench for capture_buffer with DATA_W=14, ADDR_W=4.
// Inputs change 1 time unit after a rising edge and outputs are read at the
// same point, so each step() covers exactly one sampled edge.
// -----------------------------------------------------------------------------
module tb_capture_buffer;

    localparam int DW = 14;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] din_a = '0;
    logic [DW-1:0] din_b = '0;
    logic          rd_en = 1'b0;
    logic          ramp_sel = 1'b0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;

    int checks = 0;
    int errors = 0;

    capture_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .load     (load),
        .din_a    (din_a),
        .din_b    (din_b),
        .rd_en    (rd_en),
`ifdef CAPTURE_RAMP_EN
        .ramp_sel (ramp_sel),
`endif
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; arm = 1'b0; load = 1'b0; rd_en = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic do_load(input logic [DW-1:0] a, input logic [DW-1:0] b);
        din_a = a; din_b = b; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, rd_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got busy/done/valid=%b required 000", {busy, done, rd_valid});
        end
        checks++;
        if (rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_rd_data: got %h required 00000000", rd_data);
        end
        checks++;
        if (wr_count !== 5'd0) begin
            errors++; $display("FAIL reset_wr_count: got %0d required 0", wr_count);
        end
        for (int i = 0; i < 3; i++) do_load(14'h011, 14'h022);
        checks++;
        if (wr_count !== 5'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_load_ignored: got wr_count=%0d busy=%b required 0 0", wr_count, busy);
        end
    endtask

    task automatic test_fill_read();
        logic [DW-1:0] a;
        logic [31:0]   exp;
        do_arm();
        checks++;
        if (busy !== 1'b1 || wr_count !== 5'd0) begin
            errors++; $display("FAIL arm_busy: got busy=%b wr_count=%0d required 1 0", busy, wr_count);
        end
        for (int i = 0; i < 16; i++) begin
            do_load(14'(i), 14'h3FFF - 14'(i));
            if (i == 14) begin
                checks++;
                if (wr_count !== 5'd15 || done !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL fill_15: got cnt=%0d done=%b busy=%b required 15 0 1", wr_count, done, busy);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_count !== 5'd16) begin
            errors++; $display("FAIL fill_done: got done=%b busy=%b cnt=%0d required 1 0 16", done, busy, wr_count);
        end
        rd_en = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            if (k == 0) begin
                checks++;
                if (rd_valid !== 1'b0) begin
                    errors++; $display("FAIL rd_latency: got rd_valid=%b after request edge required 0", rd_valid);
                end
            end else begin
                a = 14'(k - 1);
                exp = {2'b00, 14'h3FFF - a, 2'b00, a};
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp) begin
                    errors++; $display("FAIL rd_word%0d: got valid=%b data=%h required 1 %h", k - 1, rd_valid, rd_data, exp);
                end
            end
            if (k == 15) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++; $display("FAIL rd_last_idle: got done=%b busy=%b required 0 0", done, busy);
                end
            end
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== {2'b00, 14'h3FF0, 2'b00, 14'h000F}) begin
            errors++; $display("FAIL rd_past_end: got valid=%b data=%h required 0 3ff0000f", rd_valid, rd_data);
        end
        checks++;
        if (wr_count !== 5'd16) begin
            errors++; $display("FAIL idle_hold_count: got %0d required 16", wr_count);
        end
    endtask

    task automatic test_gapped();
        logic [31:0] exp;
        do_arm();
        for (int i = 0; i < 16; i++) begin
            do_load(14'h100 + 14'(i), 14'h200 + 14'(i));
            step(); step();
        end
        checks++;
        if (done !== 1'b1 || wr_count !== 5'd16) begin
            errors++; $display("FAIL gap_done: got done=%b cnt=%0d required 1 16", done, wr_count);
        end
        for (int i = 0; i < 3; i++) do_load(14'h3AA, 14'h155);
        checks++;
        if (wr_count !== 5'd16 || done !== 1'b1) begin
            errors++; $display("FAIL done_load_ignored: got cnt=%0d done=%b required 16 1", wr_count, done);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            step();
            if (i > 0) begin
                checks++;
                if (rd_valid !== 1'b0) begin
                    errors++; $display("FAIL gap_valid_low%0d: got %b required 0", i, rd_valid);
                end
            end
            rd_en = 1'b0;
            step();
            exp = {2'b00, 14'h200 + 14'(i), 2'b00, 14'h100 + 14'(i)};
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++; $display("FAIL gap_word%0d: got valid=%b data=%h required 1 %h", i, rd_valid, rd_data, exp);
            end
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL gap_idle: got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_collision();
        din_a = 14'h123; din_b = 14'h055; arm = 1'b1; load = 1'b1;
        step();
        arm = 1'b0; load = 1'b0;
        checks++;
        if (wr_count !== 5'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL collide_count: got cnt=%0d busy=%b required 0 1", wr_count, busy);
        end
        for (int i = 0; i < 16; i++) do_load(14'h040 + 14'(i), 14'(i));
        rd_en = 1'b1;
        step(); step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== {2'b00, 14'h0000, 2'b00, 14'h0040}) begin
            errors++; $display("FAIL collide_first: got valid=%b data=%h required 1 00000040", rd_valid, rd_data);
        end
        // Reset in the middle of readout.
        rd_en = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (wr_count !== 5'd0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            errors++; $display("FAIL midread_reset: got cnt=%0d done=%b valid=%b data=%h required 0 0 0 0", wr_count, done, rd_valid, rd_data);
        end
    endtask

    task automatic test_midfill_reset();
        do_arm();
        for (int i = 0; i < 7; i++) do_load(14'(i), 14'(i));
        checks++;
        if (wr_count !== 5'd7) begin
            errors++; $display("FAIL midfill_count: got %0d required 7", wr_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (wr_count !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midfill_reset: got cnt=%0d busy=%b done=%b required 0 0 0", wr_count, busy, done);
        end
        do_load(14'h001, 14'h001);
        checks++;
        if (wr_count !== 5'd0) begin
            errors++; $display("FAIL post_reset_idle: got cnt=%0d required 0", wr_count);
        end
    endtask

    task automatic test_rearm();
        logic [31:0] exp;
        do_arm();
        for (int i = 0; i < 16; i++) do_load(14'h1000 + 14'(i), 14'h0ABC);
        rd_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k > 0) begin
                exp = {2'b00, 14'h0ABC, 2'b00, 14'h1000 + 14'(k - 1)};
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp) begin
                    errors++; $display("FAIL rearm_rd%0d: got valid=%b data=%h required 1 %h", k - 1, rd_valid, rd_data, exp);
                end
            end
        end
        // Five reads issued; now arm together with rd_en.
        arm = 1'b1;
        step();
        arm = 1'b0; rd_en = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || wr_count !== 5'd0) begin
            errors++; $display("FAIL rearm_state: got busy=%b done=%b cnt=%0d required 1 0 0", busy, done, wr_count);
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== {2'b00, 14'h0ABC, 2'b00, 14'h1004}) begin
            errors++; $display("FAIL rearm_rd4: got valid=%b data=%h required 1 0abc1004", rd_valid, rd_data);
        end
        step();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL rearm_no_read: got rd_valid=%b required 0", rd_valid);
        end
        for (int i = 0; i < 16; i++) do_load(14'(3 * i), 14'h2000 | 14'(i));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== {2'b00, 14'h2000, 2'b00, 14'h0000}) begin
            errors++; $display("FAIL rearm_new_first: got valid=%b data=%h required 1 20000000", rd_valid, rd_data);
        end
    endtask

`ifdef CAPTURE_RAMP_EN
    task automatic test_ramp();
        logic [DW-1:0] a;
        logic [31:0]   exp;
        do_reset();
        ramp_sel = 1'b1;
        do_arm();
        for (int i = 0; i < 16; i++) do_load(14'h3FFF, 14'h3FFF);
        ramp_sel = 1'b0;
        rd_en = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            if (k > 0) begin
                a = 14'(k - 1);
                exp = {2'b00, ~a, 2'b00, a};
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp) begin
                    errors++; $display("FAIL ramp_word%0d: got valid=%b data=%h required 1 %h", k - 1, rd_valid, rd_data, exp);
                end
            end
        end
        rd_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill_read();
        test_gapped();
        test_collision();
        test_midfill_reset();
        test_rearm();
`ifdef CAPTURE_RAMP_EN
        test_ramp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
